// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL bring-up, staggered clock-output enable and lock supervision
module pll_lock_sequencer #(
  parameter int NUM_OUT             = 4,
  parameter int POWERUP_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int STAGGER_CYCLES      = 4,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               clkin,
  input  logic               resetn,
  input  logic               enable,
  input  logic               pll_lock,
  output logic               pllen,
  output logic               pll_resetn,
  output logic [NUM_OUT-1:0] clkout_en,
  output logic               ready,
  output logic               fault,
  output logic [1:0]         retry_cnt,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PWRUP     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_ENABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_RETRY     = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam int SEQ_MAX = (POWERUP_CYCLES > STAGGER_CYCLES) ? POWERUP_CYCLES : STAGGER_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [SEQ_W-1:0]   PWR_LAST = SEQ_W'(POWERUP_CYCLES - 1);
  localparam logic [SEQ_W-1:0]   STG_LAST = SEQ_W'(STAGGER_CYCLES - 1);
  localparam logic [STB_W-1:0]   STB_DONE = STB_W'(LOCK_STABLE_CYCLES);
  localparam logic [TMO_W-1:0]   TMO_DONE = TMO_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [NUM_OUT-1:0] EN_ALL   = {NUM_OUT{1'b1}};
  localparam logic [NUM_OUT-1:0] EN_ONE   = NUM_OUT'(1);

  state_t             state_q, state_d;
  logic               sync_q, lock_s_q;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [STB_W-1:0]   stb_q, stb_d, stb_nx;
  logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_nx;
  logic [NUM_OUT-1:0] en_q, en_d;
  logic [1:0]         retry_q, retry_d, retry_inc;
  logic               pllen_q, pllen_d;
  logic               prst_q, prst_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    stb_d     = stb_q;
    tmo_d     = tmo_q;
    en_d      = en_q;
    retry_d   = retry_q;
    retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
    stb_nx    = !lock_s_q ? '0 : ((stb_q == STB_DONE) ? stb_q : stb_q + STB_W'(1));
    tmo_nx    = (tmo_q == TMO_DONE) ? tmo_q : tmo_q + TMO_W'(1);

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_PWRUP;
          seq_d   = '0;
          retry_d = 2'd0;
        end
      end
      S_PWRUP: begin
        if (seq_q == PWR_LAST) begin
          state_d = S_WAIT_LOCK;
          stb_d   = '0;
          tmo_d   = '0;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        stb_d = stb_nx;
        tmo_d = tmo_nx;
        // A lock that becomes stable on the timeout cycle still counts.
        if (stb_nx == STB_DONE) begin
          state_d = S_ENABLE;
          seq_d   = '0;
          en_d    = EN_ONE;
        end else if (tmo_nx == TMO_DONE) begin
          state_d = S_RETRY;
          retry_d = retry_inc;
        end
      end
      S_ENABLE: begin
        if (!lock_s_q) begin
          state_d = S_RETRY;
          retry_d = retry_inc;
        end else if (en_q == EN_ALL) begin
          state_d = S_RUN;
          retry_d = 2'd0;
        end else if (seq_q == STG_LAST) begin
          en_d  = (en_q << 1) | EN_ONE;
          seq_d = '0;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d = S_RETRY;
          retry_d = retry_inc;
        end
      end
      S_RETRY: begin
        if ({30'd0, retry_q} == MAX_RETRIES) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_PWRUP;
          seq_d   = '0;
        end
      end
      S_FAULT: begin
        if (!enable) begin
          state_d = S_IDLE;
          retry_d = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shutdown request overrides everything except a latched fault.
    if (!enable && state_q != S_FAULT) begin
      state_d = S_IDLE;
      retry_d = 2'd0;
    end

    if (!(state_d inside {S_ENABLE, S_RUN})) en_d = '0;
    pllen_d = state_d inside {S_PWRUP, S_WAIT_LOCK, S_ENABLE, S_RUN, S_RETRY};
    prst_d  = state_d inside {S_WAIT_LOCK, S_ENABLE, S_RUN};
    ready_d = (state_d == S_RUN);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      sync_q   <= 1'b0;
      lock_s_q <= 1'b0;
      seq_q    <= '0;
      stb_q    <= '0;
      tmo_q    <= '0;
      en_q     <= '0;
      retry_q  <= 2'd0;
      pllen_q  <= 1'b0;
      prst_q   <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= pll_lock;
      lock_s_q <= sync_q;
      seq_q    <= seq_d;
      stb_q    <= stb_d;
      tmo_q    <= tmo_d;
      en_q     <= en_d;
      retry_q  <= retry_d;
      pllen_q  <= pllen_d;
      prst_q   <= prst_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  assign pllen      = pllen_q;
  assign pll_resetn = prst_q;
  assign clkout_en  = en_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - randomized and directed checks against a cycle-time model
module tb_pll_lock_sequencer;
  localparam int N = 4, P = 16, LS = 64, TMO = 128, S = 4, MR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, lock_a, pllen_a, prst_a, ready_a, fault_a;
  logic [3:0] ce_a;
  logic [1:0] rc_a;
  logic [2:0] st_a;
  logic       rst_b, en_b, lock_b, pllen_b, prst_b, ready_b, fault_b;
  logic [0:0] ce_b;
  logic [1:0] rc_b;
  logic [2:0] st_b;

  pll_lock_sequencer #(.NUM_OUT(N), .POWERUP_CYCLES(P), .LOCK_STABLE_CYCLES(LS),
    .LOCK_TIMEOUT_CYCLES(TMO), .STAGGER_CYCLES(S), .MAX_RETRIES(MR)) dut_a (
    .clkin(clk), .resetn(rst_a), .enable(en_a), .pll_lock(lock_a), .pllen(pllen_a),
    .pll_resetn(prst_a), .clkout_en(ce_a), .ready(ready_a), .fault(fault_a),
    .retry_cnt(rc_a), .state(st_a));

  pll_lock_sequencer #(.NUM_OUT(1), .POWERUP_CYCLES(2), .LOCK_STABLE_CYCLES(4),
    .LOCK_TIMEOUT_CYCLES(16), .STAGGER_CYCLES(1), .MAX_RETRIES(3)) dut_b (
    .clkin(clk), .resetn(rst_b), .enable(en_b), .pll_lock(lock_b), .pllen(pllen_b),
    .pll_resetn(prst_b), .clkout_en(ce_b), .ready(ready_b), .fault(fault_b),
    .retry_cnt(rc_b), .state(st_b));

  int checks = 0, failures = 0;
  logic cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: phase number plus cycles spent in it; outputs follow from elapsed time.
  int m_ph = 0, m_t = 0, m_stb = 0, m_ret = 0;
  logic h_old = 1'b0, h_new = 1'b0;

  always @(posedge clk) begin
    int  nph;
    logic ls;
    if (!rst_a) begin
      m_ph = 0; m_t = 0; m_stb = 0; m_ret = 0; h_old = 1'b0; h_new = 1'b0;
    end else begin
      ls = h_old; h_old = h_new; h_new = lock_a;
      nph = m_ph;
      if (m_ph != 6 && !en_a) begin
        nph = 0; m_ret = 0;
      end else begin
        case (m_ph)
          0: if (en_a) begin nph = 1; m_ret = 0; end
          1: if (m_t + 1 == P) begin nph = 2; m_stb = 0; end
          2: begin
            m_stb = ls ? m_stb + 1 : 0;
            if (m_stb == LS) nph = 3;
            else if (m_t + 1 == TMO) nph = 5;
          end
          3: if (!ls) nph = 5; else if (m_t >= (N - 1) * S) begin nph = 4; m_ret = 0; end
          4: if (!ls) nph = 5;
          5: nph = (m_ret == MR) ? 6 : 1;
          6: if (!en_a) begin nph = 0; m_ret = 0; end
          default: nph = 0;
        endcase
        if (nph == 5) m_ret = (m_ret == 3) ? 3 : m_ret + 1;
      end
      m_t = (nph != m_ph) ? 0 : m_t + 1;
      m_ph = nph;
    end
  end

  function automatic logic [12:0] exp_vec();
    int nb;
    logic [3:0] ce;
    ce = 4'h0;
    if (m_ph == 3) begin
      nb = 1 + m_t / S;
      if (nb > N) nb = N;
      ce = 4'((1 << nb) - 1);
    end else if (m_ph == 4) ce = 4'hf;
    return {3'(m_ph), 2'(m_ret), m_ph == 6, m_ph == 4, (m_ph >= 2 && m_ph <= 4),
            (m_ph >= 1 && m_ph <= 5), ce};
  endfunction

  wire [12:0] act_a = {st_a, rc_a, fault_a, ready_a, prst_a, pllen_a, ce_a};
  wire [7:0]  act_b = {st_b, rc_b, fault_b, ready_b, prst_b, pllen_b, ce_b};

  always @(negedge clk) if (cmp_on) chk("model", {19'd0, act_a}, {19'd0, exp_vec()});

  task automatic wait_state(input logic [2:0] s, input int limit, input string name);
    int n = 0;
    while (st_a !== s && n < limit) begin @(negedge clk); n++; end
    chk(name, {29'd0, st_a}, {29'd0, s});
  endtask

  initial begin
    int n;
    rst_a = 0; rst_b = 0; en_a = 0; en_b = 0; lock_a = 1; lock_b = 1;
    tick(3);
    chk("reset_a", {19'd0, act_a}, 32'd0);
    chk("reset_b", {24'd0, act_b}, 32'd0);
    rst_a = 1; rst_b = 1; cmp_on = 1;
    tick(2);

    // nominal bring-up
    en_a = 1;
    tick(1);  chk("nom_pllen", {30'd0, pllen_a, prst_a}, 32'h2);
    tick(15); chk("nom_prst_low", {31'd0, prst_a}, 32'h0);
    tick(1);  chk("nom_prst_high", {31'd0, prst_a}, 32'h1);
    tick(63); chk("nom_ce0", {28'd0, ce_a}, 32'h0);
    tick(1);  chk("nom_ce1", {28'd0, ce_a}, 32'h1);
    tick(4);  chk("nom_ce3", {28'd0, ce_a}, 32'h3);
    tick(4);  chk("nom_ce7", {28'd0, ce_a}, 32'h7);
    tick(4);  chk("nom_cef", {27'd0, ready_a, ce_a}, 32'h0f);
    tick(1);  chk("nom_ready", {24'd0, st_a, ready_a, ce_a}, {24'd0, 3'd4, 1'b1, 4'hf});

    // lock glitch in WAIT_LOCK
    en_a = 0; lock_a = 0; tick(2);
    en_a = 1; tick(17);
    chk("gl_wait", {29'd0, st_a}, 32'd2);
    lock_a = 1; tick(40);
    lock_a = 0; tick(3);
    lock_a = 1; tick(65);
    chk("gl_still_wait", {29'd0, st_a}, 32'd2);
    tick(1);
    chk("gl_enable", {23'd0, st_a, rc_a, ce_a}, {23'd0, 3'd3, 2'd0, 4'h1});
    tick(13);
    chk("gl_run", {31'd0, ready_a}, 32'd1);

    // loss of lock in RUN
    lock_a = 0; tick(2);
    chk("loss_still_run", {29'd0, st_a}, 32'd4);
    tick(1);
    chk("loss_retry", {22'd0, st_a, rc_a, ready_a, ce_a}, {22'd0, 3'd5, 2'd1, 1'b0, 4'h0});
    lock_a = 1; tick(1);
    chk("loss_pwrup", {28'd0, st_a, prst_a}, {28'd0, 3'd1, 1'b0});
    wait_state(3'd4, 200, "loss_rerun");
    chk("loss_rc_clear", {30'd0, rc_a}, 32'd0);

    // shutdown mid-sequence
    en_a = 0; tick(2); en_a = 1;
    n = 0;
    while (ce_a !== 4'h3 && n < 200) begin @(negedge clk); n++; end
    chk("sd_ce3", {28'd0, ce_a}, 32'h3);
    en_a = 0; tick(1);
    chk("sd_idle", {19'd0, act_a}, 32'd0);
    en_a = 1; tick(1);
    chk("sd_restart", {28'd0, st_a, pllen_a}, {28'd0, 3'd1, 1'b1});

    // lock never asserts
    en_a = 0; lock_a = 0; tick(2); en_a = 1;
    for (int r = 1; r <= 3; r++) begin
      wait_state(3'd5, 300, "to_retry");
      chk("to_rc", {30'd0, rc_a}, r);
      tick(1);
      if (r < 3) chk("to_pwrup", {28'd0, st_a, prst_a}, {28'd0, 3'd1, 1'b0});
      else chk("to_fault", {23'd0, st_a, fault_a, pllen_a, ce_a}, {23'd0, 3'd6, 1'b1, 1'b0, 4'h0});
    end
    tick(5);
    chk("to_fault_hold", {29'd0, st_a}, 32'd6);
    en_a = 0; tick(1);
    chk("to_clear", {26'd0, st_a, fault_a, rc_a}, 32'd0);

    // single output, unit stagger, then reset mid-RUN
    en_b = 1;
    tick(6); chk("b_wait", {29'd0, st_b}, 32'd2);
    tick(1); chk("b_enable", {27'd0, st_b, ready_b, ce_b}, {27'd0, 3'd3, 1'b0, 1'b1});
    tick(1); chk("b_run", {27'd0, st_b, ready_b, ce_b}, {27'd0, 3'd4, 1'b1, 1'b1});
    @(negedge clk); #2 rst_b = 0;
    #1 chk("b_async_reset", {24'd0, act_b}, 32'd0);
    @(negedge clk) rst_b = 1;

    // randomized enable / lock activity
    lock_a = 1; en_a = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 249) == 0) en_a = ~en_a;
      if (lock_a) begin
        if ($urandom_range(0, 299) == 0) lock_a = 0;
      end else if ($urandom_range(0, 39) == 0) lock_a = 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
